// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: iterative SubBytes engine that time-shares one bank of
// NSBOX byte S-boxes between a 128-bit state job (SubBytes) and a 32-bit
// key-word job (SubWord). Each job is processed in NSBOX-byte chunks, one
// chunk per clock. The key word wins at chunk boundaries. After a key word
// completes, one state chunk is forced before another key word can start.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   st_valid  state job request
//   st_ready  state job can be accepted
//   st_in     128-bit state, byte k = bits [8k+7:8k]
//   st_out    SubBytes result, held between st_done pulses
//   st_done   one-cycle pulse, st_out updated this cycle
//   kw_valid  key-word job request
//   kw_ready  key-word job can be accepted
//   kw_in     32-bit key word, byte k = bits [8k+7:8k]
//   kw_out    SubWord result, held between kw_done pulses
//   kw_done   one-cycle pulse, kw_out updated this cycle

// sbox: combinational AES forward S-box, one byte in, one byte out.
module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Entry 0x00 occupies the top byte, so byte v sits at bit offset (255-v)*8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~din equals 255-din for an 8-bit value.
  assign dout = SBOX_TABLE[{~din, 3'b000} +: 8];
endmodule

module sbox_share_ctrl #(
  parameter int NSBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_in,
  output logic [31:0]  kw_out,
  output logic         kw_done
);
  localparam int ST_CHUNKS = 16 / NSBOX;
  // With more than four S-boxes only lanes 0..3 serve the key word.
  localparam int KW_LANES  = (NSBOX < 4) ? NSBOX : 4;
  localparam int KW_CHUNKS = 4 / KW_LANES;
  localparam int STCW      = (ST_CHUNKS > 1) ? $clog2(ST_CHUNKS) : 1;
  localparam int KWCW      = (KW_CHUNKS > 1) ? $clog2(KW_CHUNKS) : 1;
  localparam logic [STCW-1:0] ST_LAST = STCW'(ST_CHUNKS - 1);
  localparam logic [KWCW-1:0] KW_LAST = KWCW'(KW_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ST_RUN,
    KW_RUN
  } state_t;

  state_t          state_reg, state_next;
  logic            st_pending_reg, st_pending_next;
  logic            kw_pending_reg, kw_pending_next;
  logic            force_st_reg, force_st_next;
  logic [STCW-1:0] st_cnt_reg, st_cnt_next;
  logic [KWCW-1:0] kw_cnt_reg, kw_cnt_next;
  logic [127:0]    st_work_reg, st_work_next;
  logic [31:0]     kw_work_reg, kw_work_next;
  logic [127:0]    st_out_reg, st_out_next;
  logic [31:0]     kw_out_reg, kw_out_next;
  logic            st_done_reg, st_done_next;
  logic            kw_done_reg, kw_done_next;

  logic [7:0] lane_in  [NSBOX];
  logic [7:0] lane_out [NSBOX];
  logic [3:0] st_idx   [NSBOX];
  logic [1:0] kw_idx   [KW_LANES];

  logic st_accept, kw_accept, st_last, kw_last;

  assign st_ready  = !st_pending_reg && !rst;
  assign kw_ready  = !kw_pending_reg && !rst;
  assign st_accept = st_valid && st_ready;
  assign kw_accept = kw_valid && kw_ready;
  assign st_last   = (state_reg == ST_RUN) && (st_cnt_reg == ST_LAST);
  assign kw_last   = (state_reg == KW_RUN) && (kw_cnt_reg == KW_LAST);

  assign st_out  = st_out_reg;
  assign kw_out  = kw_out_reg;
  assign st_done = st_done_reg;
  assign kw_done = kw_done_reg;

  // S-box bank: lane gi handles byte (chunk*lanes + gi) of whichever job runs.
  generate
    for (genvar gi = 0; gi < NSBOX; gi++) begin : g_lane
      assign st_idx[gi] = 4'(int'(st_cnt_reg) * NSBOX + gi);
      if (gi < KW_LANES) begin : g_kw
        assign kw_idx[gi]  = 2'(int'(kw_cnt_reg) * KW_LANES + gi);
        assign lane_in[gi] = (state_reg == KW_RUN) ?
                             kw_work_reg[{kw_idx[gi], 3'b000} +: 8] :
                             st_work_reg[{st_idx[gi], 3'b000} +: 8];
      end else begin : g_st_only
        assign lane_in[gi] = st_work_reg[{st_idx[gi], 3'b000} +: 8];
      end
      sbox u_sbox (
        .din  (lane_in[gi]),
        .dout (lane_out[gi])
      );
    end
  endgenerate

  always_comb begin
    st_pending_next = st_pending_reg;
    kw_pending_next = kw_pending_reg;
    force_st_next   = force_st_reg;
    st_cnt_next     = st_cnt_reg;
    kw_cnt_next     = kw_cnt_reg;
    st_work_next    = st_work_reg;
    kw_work_next    = kw_work_reg;
    st_out_next     = st_out_reg;
    kw_out_next     = kw_out_reg;
    st_done_next    = 1'b0;
    kw_done_next    = 1'b0;
    state_next      = IDLE;

    if (state_reg == ST_RUN) begin
      for (int i = 0; i < NSBOX; i++) begin
        st_work_next[{st_idx[i], 3'b000} +: 8] = lane_out[i];
      end
      // The forced chunk after a key word has now been issued.
      force_st_next = 1'b0;
      st_cnt_next   = st_last ? '0 : st_cnt_reg + STCW'(1);
      if (st_last) begin
        st_out_next     = st_work_next;
        st_done_next    = 1'b1;
        st_pending_next = 1'b0;
      end
    end

    if (state_reg == KW_RUN) begin
      for (int i = 0; i < KW_LANES; i++) begin
        kw_work_next[{kw_idx[i], 3'b000} +: 8] = lane_out[i];
      end
      kw_cnt_next = kw_last ? '0 : kw_cnt_reg + KWCW'(1);
      if (kw_last) begin
        kw_out_next     = kw_work_next;
        kw_done_next    = 1'b1;
        kw_pending_next = 1'b0;
      end
    end

    // Acceptance only happens on an idle path, so it never collides with
    // the chunk write-back of the same path above.
    if (st_accept) begin
      st_work_next    = st_in;
      st_pending_next = 1'b1;
    end
    if (kw_accept) begin
      kw_work_next    = kw_in;
      kw_pending_next = 1'b1;
    end

    // Anti-starvation: a completing key word hands the next chunk to a
    // waiting state job, even if another key word is already queued.
    if (kw_last && st_pending_next) begin
      force_st_next = 1'b1;
    end

    // Decide next cycle's chunk from next-cycle flags so a job accepted at
    // an edge starts its first chunk in the very next cycle.
    if (kw_pending_next && !force_st_next) begin
      state_next = KW_RUN;
    end else if (st_pending_next) begin
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      st_pending_reg <= 1'b0;
      kw_pending_reg <= 1'b0;
      force_st_reg   <= 1'b0;
      st_cnt_reg     <= '0;
      kw_cnt_reg     <= '0;
      st_work_reg    <= '0;
      kw_work_reg    <= '0;
      st_out_reg     <= '0;
      kw_out_reg     <= '0;
      st_done_reg    <= 1'b0;
      kw_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      st_pending_reg <= st_pending_next;
      kw_pending_reg <= kw_pending_next;
      force_st_reg   <= force_st_next;
      st_cnt_reg     <= st_cnt_next;
      kw_cnt_reg     <= kw_cnt_next;
      st_work_reg    <= st_work_next;
      kw_work_reg    <= kw_work_next;
      st_out_reg     <= st_out_next;
      kw_out_reg     <= kw_out_next;
      st_done_reg    <= st_done_next;
      kw_done_reg    <= kw_done_next;
    end
  end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: three instances (NSBOX = 1, 4, 16) driven by the
// same stimulus, each compared cycle by cycle against a job-level reference
// model, plus directed result/latency checks.
module tb_sbox_share_ctrl;
  localparam int NCFG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         st_valid, kw_valid;
  logic [127:0] st_in;
  logic [31:0]  kw_in;

  logic         st_ready_w [NCFG];
  logic         kw_ready_w [NCFG];
  logic         st_done_w  [NCFG];
  logic         kw_done_w  [NCFG];
  logic [127:0] st_out_w   [NCFG];
  logic [31:0]  kw_out_w   [NCFG];

  int st_lat_a      [NCFG];
  int kw_lat_a      [NCFG];
  int st_done_cnt_a [NCFG];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] ref_tab [256];

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, t, s;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gf_mul(inv, x);
    s = inv; t = inv;
    for (int k = 0; k < 4; k++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tab[x[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_tab[x[8*k +: 8]];
    return r;
  endfunction

  function automatic int ns_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
  endfunction

  function automatic int stc_of(input int i);
    return 16 / ns_of(i);
  endfunction

  function automatic int kwc_of(input int i);
    return (ns_of(i) >= 4) ? 1 : 4 / ns_of(i);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int NS  = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
    localparam int STC = 16 / NS;
    localparam int KWC = (NS >= 4) ? 1 : 4 / NS;

    sbox_share_ctrl #(.NSBOX(NS)) dut (
      .clk      (clk),
      .rst      (rst),
      .st_valid (st_valid),
      .st_ready (st_ready_w[gi]),
      .st_in    (st_in),
      .st_out   (st_out_w[gi]),
      .st_done  (st_done_w[gi]),
      .kw_valid (kw_valid),
      .kw_ready (kw_ready_w[gi]),
      .kw_in    (kw_in),
      .kw_out   (kw_out_w[gi]),
      .kw_done  (kw_done_w[gi])
    );

    // Job-level reference: remaining chunk counts per job, results computed
    // as whole-word SubBytes/SubWord on completion.
    bit           m_st_busy, m_kw_busy, m_force, m_st_done, m_kw_done;
    bit           st_rdy, kw_rdy;
    int           m_st_left, m_kw_left;
    logic [127:0] m_st_data, m_st_out;
    logic [31:0]  m_kw_data, m_kw_out;
    int           st_acc, kw_acc;

    initial begin
      m_st_busy = 0; m_kw_busy = 0; m_force = 0; m_st_done = 0; m_kw_done = 0;
      m_st_left = 0; m_kw_left = 0;
      m_st_data = '0; m_st_out = '0; m_kw_data = '0; m_kw_out = '0;
      forever begin
        @(posedge clk);
        if (rst) begin
          m_st_busy = 0; m_kw_busy = 0; m_force = 0;
          m_st_done = 0; m_kw_done = 0;
          m_st_out = '0; m_kw_out = '0;
        end else begin
          st_rdy = !m_st_busy;
          kw_rdy = !m_kw_busy;
          m_st_done = 0;
          m_kw_done = 0;
          if (m_kw_busy && !m_force) begin
            m_kw_left--;
            if (m_kw_left == 0) begin
              m_kw_busy = 0;
              m_kw_out  = sub_word(m_kw_data);
              m_kw_done = 1;
            end
          end else if (m_st_busy) begin
            m_force = 0;
            m_st_left--;
            if (m_st_left == 0) begin
              m_st_busy = 0;
              m_st_out  = sub_bytes(m_st_data);
              m_st_done = 1;
            end
          end
          if (st_valid && st_rdy) begin
            m_st_busy = 1; m_st_data = st_in; m_st_left = STC;
          end
          if (kw_valid && kw_rdy) begin
            m_kw_busy = 1; m_kw_data = kw_in; m_kw_left = KWC;
          end
          if (m_kw_done && m_st_busy) m_force = 1;
        end
      end
    end

    // Per-cycle comparison plus DUT-side latency bookkeeping (edge numbers).
    initial begin
      st_acc = 0;
      kw_acc = 0;
      forever begin
        @(posedge clk);
        #3;
        check_val($sformatf("n%0d_st_ready", NS), 128'(st_ready_w[gi]), 128'(!m_st_busy && !rst));
        check_val($sformatf("n%0d_kw_ready", NS), 128'(kw_ready_w[gi]), 128'(!m_kw_busy && !rst));
        check_val($sformatf("n%0d_st_done", NS), 128'(st_done_w[gi]), 128'(m_st_done));
        check_val($sformatf("n%0d_kw_done", NS), 128'(kw_done_w[gi]), 128'(m_kw_done));
        check_val($sformatf("n%0d_st_out", NS), st_out_w[gi], m_st_out);
        check_val($sformatf("n%0d_kw_out", NS), 128'(kw_out_w[gi]), 128'(m_kw_out));
        if (st_done_w[gi] === 1'b1) begin
          st_lat_a[gi] = cyc - st_acc;
          st_done_cnt_a[gi]++;
        end
        if (kw_done_w[gi] === 1'b1) kw_lat_a[gi] = cyc - kw_acc;
        if (st_valid && st_ready_w[gi] === 1'b1) st_acc = cyc + 1;
        if (kw_valid && kw_ready_w[gi] === 1'b1) kw_acc = cyc + 1;
      end
    end
  end

  task automatic drive(input bit sv, input logic [127:0] si,
                       input bit kv, input logic [31:0] ki);
    @(posedge clk);
    #1;
    st_valid = sv; st_in = si; kw_valid = kv; kw_in = ki;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, rand128(), 1'b0, $urandom);
  endtask

  task automatic clear_lat();
    for (int i = 0; i < NCFG; i++) begin
      st_lat_a[i] = -1;
      kw_lat_a[i] = -1;
    end
  endtask

  logic [127:0] st_data;

  initial begin
    rst = 1'b1; st_valid = 1'b0; kw_valid = 1'b0; st_in = '0; kw_in = '0;
    for (int i = 0; i < NCFG; i++) st_done_cnt_a[i] = 0;
    for (int v = 0; v < 256; v++) ref_tab[v] = sbox_ref(8'(v));
    clear_lat();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Lone all-zero state job.
    clear_lat();
    drive(1'b1, 128'h0, 1'b0, 32'h0);
    idle(40);
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("t1_st_out_n%0d", ns_of(i)), st_out_w[i], {16{8'h63}});
      check_val($sformatf("t1_st_lat_n%0d", ns_of(i)), 128'(st_lat_a[i]), 128'(stc_of(i)));
    end

    // Lone key word.
    clear_lat();
    drive(1'b0, 128'h0, 1'b1, 32'hcf4f3c09);
    idle(10);
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("t2_kw_out_n%0d", ns_of(i)), 128'(kw_out_w[i]), 128'h8a84eb01);
      check_val($sformatf("t2_kw_lat_n%0d", ns_of(i)), 128'(kw_lat_a[i]), 128'(kwc_of(i)));
    end

    // Key word arrives one cycle into a state job.
    clear_lat();
    drive(1'b1, {16{8'h53}}, 1'b0, 32'h0);
    drive(1'b0, 128'h0, 1'b1, 32'hcf4f3c09);
    idle(40);
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("t3_st_out_n%0d", ns_of(i)), st_out_w[i], {16{8'hed}});
      check_val($sformatf("t3_kw_out_n%0d", ns_of(i)), 128'(kw_out_w[i]), 128'h8a84eb01);
      check_val($sformatf("t3_kw_lat_n%0d", ns_of(i)), 128'(kw_lat_a[i]), 128'(kwc_of(i)));
      check_val($sformatf("t3_st_lat_n%0d", ns_of(i)), 128'(st_lat_a[i]),
                128'((stc_of(i) > 1) ? stc_of(i) + kwc_of(i) : stc_of(i)));
    end

    // Simultaneous start with the key-word request held continuously.
    clear_lat();
    st_data = rand128();
    drive(1'b1, st_data, 1'b1, $urandom);
    repeat (90) drive(1'b0, rand128(), 1'b1, $urandom);
    idle(20);
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("t4_st_out_n%0d", ns_of(i)), st_out_w[i], sub_bytes(st_data));
      check_val($sformatf("t4_st_lat_n%0d", ns_of(i)), 128'(st_lat_a[i]),
                128'(stc_of(i) * (kwc_of(i) + 1)));
    end

    // Reset two chunks into a state job.
    for (int i = 0; i < NCFG; i++) st_done_cnt_a[i] = 0;
    drive(1'b1, rand128(), 1'b0, 32'h0);
    idle(2);
    @(posedge clk);
    #1 rst = 1'b1; st_valid = 1'b0; kw_valid = 1'b0;
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("t5_st_ready_rst_n%0d", ns_of(i)), 128'(st_ready_w[i]), 128'(0));
      check_val($sformatf("t5_kw_ready_rst_n%0d", ns_of(i)), 128'(kw_ready_w[i]), 128'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("t5_st_out_n%0d", ns_of(i)), st_out_w[i], 128'h0);
      check_val($sformatf("t5_kw_out_n%0d", ns_of(i)), 128'(kw_out_w[i]), 128'h0);
      check_val($sformatf("t5_st_done_cnt_n%0d", ns_of(i)), 128'(st_done_cnt_a[i]),
                128'((stc_of(i) <= 2) ? 1 : 0));
    end
    clear_lat();
    st_data = rand128();
    drive(1'b1, st_data, 1'b0, 32'h0);
    idle(30);
    for (int i = 0; i < NCFG; i++) begin
      check_val($sformatf("t5_fresh_out_n%0d", ns_of(i)), st_out_w[i], sub_bytes(st_data));
      check_val($sformatf("t5_fresh_lat_n%0d", ns_of(i)), 128'(st_lat_a[i]), 128'(stc_of(i)));
    end

    // Random traffic with occasional resets; the per-cycle model does the checking.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #1 rst = 1'b1; st_valid = 1'b0; kw_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        drive($urandom_range(0, 99) < 35, rand128(), $urandom_range(0, 99) < 35, $urandom);
      end
    end
    idle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
